imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Sequences the program load into the instruction memory during the debug/boot phase. It takes a byte stream (e.g. from the UART receiver), assembles big-endian 32-bit words (first byte received = bits 31:24), and issues single-cycle writes to consecutive word addresses starting at 0. The load terminates on the HALT instruction or when memory is full, then reports done so the debug unit can release the CPU.

Parameters:
NBITS, 8, width of one memory cell / received byte
INST_BITS, 32, instruction and address width
CELLS, 256, memory size in bytes; must be a multiple of 4
HALT_INSTR, 32'hFFFFFFFF, instruction word that ends the load

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  begin (or restart) a load; one-cycle pulse
i_rx_data  in  NBITS  received byte
i_rx_valid  in  1  i_rx_data valid this cycle; one byte per high cycle
o_wr_en  out  1  write strobe to instruction memory write-enable input
o_wr_addr  out  INST_BITS  byte address of the word being written (to memory write-address input)
o_wr_data  out  INST_BITS  assembled word (to memory write-data input)
o_busy  out  1  load in progress
o_done  out  1  load finished; sticky
o_full  out  1  load ended because memory filled without HALT; sticky
o_word_cnt  out  INST_BITS  number of words written in the current or last load

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; internal byte counter and assembly register 0.
- All outputs are registered; updates on posedge i_clk. The memory samples on negedge, so o_wr_en/addr/data are held stable for one full cycle.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE: o_busy=0. i_start -> LOAD; clear wr_addr, word_cnt, byte_cnt, o_done, o_full.
- LOAD: o_busy=1. Each cycle with i_rx_valid: asm <= {asm[23:0], i_rx_data}; byte_cnt++. On the 4th byte: o_wr_data <= completed word, o_wr_en <= 1, go to WRITE; byte_cnt <= 0.
- Latency: 4th byte valid at edge k -> o_wr_en high from edge k+1 to k+2, exactly one cycle.
- WRITE: o_wr_en=1 for this cycle only. A byte valid during WRITE is accepted as byte 0 of the next word (byte_cnt becomes 1), never dropped. Exit at the next edge:
  - o_wr_data == HALT_INSTR -> DONE; HALT is written to memory; word_cnt++; o_wr_addr unchanged.
  - else if o_wr_addr == CELLS-4 -> DONE with o_full=1; word_cnt++.
  - else o_wr_addr += 4; word_cnt++; -> LOAD.
- DONE: o_busy=0, o_done=1, o_wr_en=0; i_rx_valid ignored. i_start restarts the load exactly as from IDLE.
- i_start in LOAD or WRITE is ignored.
- A partial word (1-3 bytes) is never written; it is discarded on reset or restart.
- Reset mid-load: immediate return to IDLE with outputs 0; memory contents already written are left as is.
- Address arithmetic is modulo 2^INST_BITS, but the full check prevents o_wr_addr from exceeding CELLS-4.

Decomposition:
- Shared package (cpu_pkg): state encoding, HALT_INSTR, and the INST_BITS/NBITS constants shared with the instruction memory and debug unit.
- One natural sub-module, word_assembler: byte shift register plus 2-bit counter, with a word_ready pulse and a clear input. The FSM stays in imem_loader.

Test Plan:
- Start, then send bytes 20 08 00 05, 00 00 00 00, FF FF FF FF -> writes (addr 0, 0x20080005), (4, 0x00000000), (8, 0xFFFFFFFF); o_done=1, o_full=0, o_word_cnt=3. Reading the memory back returns the same words.
- Byte order: send 11 22 33 44 with gaps of 0-7 idle cycles between bytes -> single write of 0x11223344 at addr 0, one cycle after the 4th byte.
- CELLS=16, send 16 non-HALT bytes -> writes at 0, 4, 8, 12; then o_done=1, o_full=1, o_word_cnt=4; further bytes produce no write.
- Byte valid in the WRITE cycle: send AA BB CC DD EE with no gaps, then 00 00 00 -> writes 0xAABBCCDD at 0 and 0xEE000000 at 4.
- Assert i_rst_n=0 asynchronously after 2 bytes of word 1 -> all outputs 0 immediately. Restart and send 4 bytes -> first write at addr 0 containing only the new bytes.
- i_start pulse mid-load -> ignored, addressing continues. i_start in DONE -> o_done clears, loading restarts at addr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The width constants and HALT encoding match the instruction memory and the
// debug unit.
package imem_loader_pkg;

  localparam int                CPU_NBITS      = 8;
  localparam int                CPU_INST_BITS  = 32;
  localparam logic [31:0]       CPU_HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Byte-to-word assembler for the instruction-memory loader.
// Shifts accepted bytes in big-endian order (first byte ends up in the top
// byte) and flags the cycle in which the fourth byte arrives.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clear       drop any partial word (restart)
//   accept      loader is willing to take bytes this cycle
//   data, valid incoming byte and its strobe
//   word        completed word: the stored three bytes plus the current byte
//   word_ready  high in the cycle the fourth byte is accepted
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int NBITS     = CPU_NBITS,
  parameter int INST_BITS = CPU_INST_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [NBITS-1:0]     data,
  input  logic                 valid,
  output logic [INST_BITS-1:0] word,
  output logic                 word_ready
);

  // Only the three oldest bytes need storage; the fourth is taken straight
  // from the input when the word completes.
  logic [INST_BITS-NBITS-1:0] asm_q;
  logic [1:0]                 cnt_q;
  logic                       take;

  assign take       = accept && valid;
  assign word       = {asm_q, data};
  assign word_ready = take && (cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q <= '0;
      cnt_q <= 2'd0;
    end else if (clear) begin
      asm_q <= '0;
      cnt_q <= 2'd0;
    end else if (take) begin
      asm_q <= word[INST_BITS-NBITS-1:0];
      cnt_q <= cnt_q + 2'd1;  // wraps to 0 after the fourth byte
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory program loader.
// Assembles a received byte stream into big-endian words and writes them to
// consecutive word addresses from 0 until HALT is written or memory fills.
// Ports:
//   i_clk, i_rst_n  clock / async active-low reset
//   i_start         one-cycle pulse: begin or restart a load
//   i_rx_data/valid received byte stream, one byte per valid cycle
//   o_wr_en/addr/data single-cycle memory write, held for a full clock
//   o_busy          load in progress
//   o_done, o_full  load finished / finished because memory filled (sticky)
//   o_word_cnt      words written in the current or last load
//
// state    | meaning
// ST_IDLE  | after reset, waiting for i_start
// ST_LOAD  | collecting bytes of the next word
// ST_WRITE | write strobe asserted for this cycle; next byte may arrive
// ST_DONE  | load finished, byte stream ignored until i_start
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                   NBITS      = CPU_NBITS,
  parameter int                   INST_BITS  = CPU_INST_BITS,
  parameter int                   CELLS      = 256,
  parameter logic [INST_BITS-1:0] HALT_INSTR = CPU_HALT_INSTR
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [NBITS-1:0]     i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_wr_en,
  output logic [INST_BITS-1:0] o_wr_addr,
  output logic [INST_BITS-1:0] o_wr_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_full,
  output logic [INST_BITS-1:0] o_word_cnt
);

  localparam logic [INST_BITS-1:0] LAST_ADDR = INST_BITS'(CELLS - 4);
  localparam logic [INST_BITS-1:0] STEP      = INST_BITS'(4);
  localparam logic [INST_BITS-1:0] ONE       = INST_BITS'(1);

  state_t                 state;
  logic                   accept;
  logic                   clear;
  logic [INST_BITS-1:0]   word;
  logic                   word_ready;

  // Bytes are taken in WRITE too, so a byte arriving right after the fourth
  // one becomes byte 0 of the next word instead of being lost.
  assign accept = (state == ST_LOAD) || (state == ST_WRITE);
  assign clear  = i_start && ((state == ST_IDLE) || (state == ST_DONE));

  word_assembler #(
    .NBITS     (NBITS),
    .INST_BITS (INST_BITS)
  ) u_asm (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .clear      (clear),
    .accept     (accept),
    .data       (i_rx_data),
    .valid      (i_rx_valid),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_full     <= 1'b0;
      o_word_cnt <= '0;
    end else begin
      o_wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state      <= ST_LOAD;
            o_wr_addr  <= '0;
            o_word_cnt <= '0;
            o_busy     <= 1'b1;
            o_done     <= 1'b0;
            o_full     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (word_ready) begin
            o_wr_data <= word;
            o_wr_en   <= 1'b1;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          o_word_cnt <= o_word_cnt + ONE;
          if (o_wr_data == HALT_INSTR) begin
            // HALT itself is written; address stays on the HALT word.
            state  <= ST_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else if (o_wr_addr == LAST_ADDR) begin
            state  <= ST_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_full <= 1'b1;
          end else begin
            o_wr_addr <= o_wr_addr + STEP;
            state     <= ST_LOAD;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_wr_en;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_busy;
  logic        o_done;
  logic        o_full;
  logic [31:0] o_word_cnt;

  imem_loader #(
    .NBITS      (8),
    .INST_BITS  (32),
    .CELLS      (16),
    .HALT_INSTR (32'hFFFF_FFFF)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_full     (o_full),
    .o_word_cnt (o_word_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  // Memory model: samples the write port on negedge like the real memory.
  logic [31:0] mem [0:3];
  logic [31:0] cap_addr [$];
  logic [31:0] cap_data [$];
  int          nwr = 0;
  int          dbl_we = 0;
  logic        prev_we = 1'b0;

  always @(negedge i_clk) begin
    if (o_wr_en) begin
      if (prev_we) dbl_we++;
      cap_addr.push_back(o_wr_addr);
      cap_data.push_back(o_wr_data);
      mem[o_wr_addr[3:2]] = o_wr_data;
      nwr++;
    end
    prev_we = o_wr_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  typedef struct packed {
    logic        start;
    logic [31:0] bytes;
    logic [2:0]  gap;
    logic [31:0] exp_addr;
    logic [31:0] exp_cnt;
    logic        exp_done;
    logic        exp_full;
  } row_t;

  row_t tbl [7];

  initial begin
    logic [31:0] w;
    int          base;

    tbl[0] = '{1'b1, 32'h2008_0005, 3'd0, 32'd0,  32'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h0000_0000, 3'd1, 32'd4,  32'd2, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF, 3'd2, 32'd8,  32'd3, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 32'h1122_3344, 3'd5, 32'd0,  32'd1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 32'h0102_0304, 3'd3, 32'd4,  32'd2, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 32'h0506_0708, 3'd0, 32'd8,  32'd3, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 32'h090A_0B0C, 3'd4, 32'd12, 32'd4, 1'b1, 1'b1};

    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;

    repeat (2) @(negedge i_clk);
    chk("rst wr_en",    32'(o_wr_en), 32'd0);
    chk("rst wr_addr",  o_wr_addr,    32'd0);
    chk("rst wr_data",  o_wr_data,    32'd0);
    chk("rst busy",     32'(o_busy),  32'd0);
    chk("rst done",     32'(o_done),  32'd0);
    chk("rst full",     32'(o_full),  32'd0);
    chk("rst word_cnt", o_word_cnt,   32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    idle(1);

    // Table: HALT-terminated load, then a restart from DONE that fills memory.
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].start) pulse_start();
      w = tbl[i].bytes;
      for (int j = 0; j < 4; j++) begin
        send_byte(w[31-8*j -: 8]);
        if (j < 3) idle((int'(tbl[i].gap) + j) % 8);
      end
      @(negedge i_clk);
      chk("write latency", 32'(o_wr_en), 32'd1);
      chk("write addr",    o_wr_addr,    tbl[i].exp_addr);
      chk("write data",    o_wr_data,    w);
      chk("busy in write", 32'(o_busy),  32'd1);
      @(negedge i_clk);
      chk("write pulse",   32'(o_wr_en), 32'd0);
      chk("word_cnt",      o_word_cnt,   tbl[i].exp_cnt);
      chk("done",          32'(o_done),  32'(tbl[i].exp_done));
      chk("full",          32'(o_full),  32'(tbl[i].exp_full));
      chk("busy",          32'(o_busy),  32'(!tbl[i].exp_done));
      if (i == 2) begin
        chk("readback 0", mem[0], 32'h2008_0005);
        chk("readback 1", mem[1], 32'h0000_0000);
        chk("readback 2", mem[2], 32'hFFFF_FFFF);
      end
    end

    // Memory full: further bytes must not write.
    base = nwr;
    for (int j = 0; j < 4; j++) send_byte(8'h55);
    idle(3);
    chk("no write after full", 32'(nwr),    32'(base));
    chk("done stays",          32'(o_done), 32'd1);
    chk("full stays",          32'(o_full), 32'd1);

    // Byte arriving in the WRITE cycle starts the next word.
    pulse_start();
    base = nwr;
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_byte(8'hDD); send_byte(8'hEE);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(3);
    chk("wc writes", 32'(nwr), 32'(base + 2));
    if (nwr >= base + 2) begin
      chk("wc addr0", cap_addr[base],     32'd0);
      chk("wc data0", cap_data[base],     32'hAABB_CCDD);
      chk("wc addr1", cap_addr[base + 1], 32'd4);
      chk("wc data1", cap_data[base + 1], 32'hEE00_0000);
    end
    chk("wc word_cnt", o_word_cnt,  32'd2);
    chk("wc full",     32'(o_full), 32'd0);

    // Start pulse mid-word is ignored; assembly and addressing continue.
    send_byte(8'h12); send_byte(8'h34);
    pulse_start();
    send_byte(8'h56); send_byte(8'h78);
    @(negedge i_clk);
    chk("midstart wr_en", 32'(o_wr_en), 32'd1);
    chk("midstart addr",  o_wr_addr,    32'd8);
    chk("midstart data",  o_wr_data,    32'h1234_5678);
    @(negedge i_clk);
    chk("midstart word_cnt", o_word_cnt, 32'd3);

    // Asynchronous reset after two bytes of a word.
    send_byte(8'hAB); send_byte(8'hCD);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst busy",     32'(o_busy),  32'd0);
    chk("arst wr_addr",  o_wr_addr,    32'd0);
    chk("arst wr_data",  o_wr_data,    32'd0);
    chk("arst word_cnt", o_word_cnt,   32'd0);
    chk("arst done",     32'(o_done),  32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    idle(1);
    pulse_start();
    send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
    @(negedge i_clk);
    chk("post-rst wr_en", 32'(o_wr_en), 32'd1);
    chk("post-rst addr",  o_wr_addr,    32'd0);
    chk("post-rst data",  o_wr_data,    32'h9ABC_DEF0);
    idle(2);

    chk("wr_en single cycle", 32'(dbl_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
